traffic_light_fsm: RTL and testbench

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

---
 rtl/traffic_light_fsm_if.sv | 35 +++
 rtl/traffic_light_fsm.sv | 126 ++++++++++++
 tb/tb_traffic_light_fsm.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_fsm_if.sv
// Signal bundle between the traffic-light controller and its environment
// (timebase, vehicle sensor, walk register and lamp drivers).
interface traffic_light_fsm_if;

   logic       tick;
   logic       sensor;
   logic       wr;
   logic       wr_reset;
   logic [2:0] main_lights;
   logic [2:0] side_lights;
   logic       walk_lamp;

   // Environment side: supplies timebase/requests, observes lamps and clear pulse
   modport master (
      output tick,
      output sensor,
      output wr,
      input  wr_reset,
      input  main_lights,
      input  side_lights,
      input  walk_lamp
   );

   // Controller side
   modport slave (
      input  tick,
      input  sensor,
      input  wr,
      output wr_reset,
      output main_lights,
      output side_lights,
      output walk_lamp
   );

endinterface

// File: rtl/traffic_light_fsm.sv
// Main/side street traffic-light controller with vehicle-sensor green extension
// and a pedestrian walk phase, timed by a tick-enabled 4-bit down-counter.
module traffic_light_fsm #(
   parameter int T_BASE = 6,
   parameter int T_EXT  = 3,
   parameter int T_YEL  = 2
) (
   input logic                 clk,
   input logic                 reset_n,
   traffic_light_fsm_if.slave  bus
);

   localparam logic [3:0] T_BASE4 = 4'(T_BASE);
   localparam logic [3:0] T_EXT4  = 4'(T_EXT);
   localparam logic [3:0] T_YEL4  = 4'(T_YEL);

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   typedef enum logic [2:0] {
      MG1  = 3'd0,
      MG2  = 3'd1,
      MY   = 3'd2,
      WALK = 3'd3,
      SG   = 3'd4,
      SY   = 3'd5
   } state_t;

   state_t     state;
   state_t     nxt_state;
   logic [3:0] timer;
   logic [3:0] nxt_timer;
   logic       advance;

   function automatic logic [2:0] main_of(state_t s);
      case (s)
         MG1, MG2: main_of = LAMP_GRN;
         MY:       main_of = LAMP_YEL;
         default:  main_of = LAMP_RED;
      endcase
   endfunction

   function automatic logic [2:0] side_of(state_t s);
      case (s)
         SG:      side_of = LAMP_GRN;
         SY:      side_of = LAMP_YEL;
         default: side_of = LAMP_RED;
      endcase
   endfunction

   // A tick on the last count of a state is spent on the transition itself,
   // so the freshly loaded duration is not decremented in that same cycle.
   always_comb begin
      nxt_state = state;
      nxt_timer = timer;
      advance   = 1'b0;
      if (bus.tick) begin
         if (timer > 4'd1) begin
            nxt_timer = timer - 4'd1;
         end else begin
            advance = 1'b1;
            case (state)
               MG1: begin
                  nxt_state = MG2;
                  nxt_timer = bus.sensor ? T_EXT4 : T_BASE4;
               end
               MG2: begin
                  nxt_state = MY;
                  nxt_timer = T_YEL4;
               end
               MY: begin
                  if (bus.wr) begin
                     nxt_state = WALK;
                     nxt_timer = T_EXT4;
                  end else begin
                     nxt_state = SG;
                     nxt_timer = T_BASE4;
                  end
               end
               WALK: begin
                  nxt_state = SG;
                  nxt_timer = T_BASE4;
               end
               SG: begin
                  nxt_state = SY;
                  nxt_timer = T_YEL4;
               end
               default: begin
                  nxt_state = MG1;
                  nxt_timer = T_BASE4;
               end
            endcase
         end
      end
   end

   // Lamps are decoded from the next state so they change on the same edge
   // as the state register; the walk-register clear fires only on WALK entry.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state           <= MG1;
         timer           <= T_BASE4;
         bus.main_lights <= LAMP_GRN;
         bus.side_lights <= LAMP_RED;
         bus.walk_lamp   <= 1'b0;
         bus.wr_reset    <= 1'b0;
      end else begin
         state           <= nxt_state;
         timer           <= nxt_timer;
         bus.main_lights <= main_of(nxt_state);
         bus.side_lights <= side_of(nxt_state);
         bus.walk_lamp   <= (nxt_state == WALK);
         bus.wr_reset    <= advance && (nxt_state == WALK);
      end
   end

   // Conflicting greens must be impossible whatever the inputs do
   a_one_street_red: assert property (@(posedge clk) disable iff (!reset_n)
      (bus.main_lights == LAMP_RED) || (bus.side_lights == LAMP_RED));
   a_main_onehot: assert property (@(posedge clk) disable iff (!reset_n)
      $onehot(bus.main_lights));
   a_side_onehot: assert property (@(posedge clk) disable iff (!reset_n)
      $onehot(bus.side_lights));

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench: a table of stimulus segments with hand-derived lamp
// expectations, expanded per cycle and checked through a scoreboard queue.
module tb_traffic_light_fsm;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   typedef struct {
      string      name;
      int         n;
      int         mode;
      logic       rst_n;
      logic       sensor;
      logic       wr;
      logic [2:0] main;
      logic [2:0] side;
      logic       walk;
      logic       wrr;
   } seg_t;

   typedef struct {
      string      name;
      int         idx;
      logic       rst_n;
      logic       tick;
      logic       sensor;
      logic       wr;
      logic [2:0] main;
      logic [2:0] side;
      logic       walk;
      logic       wrr;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   seg_t segs[$];
   vec_t vecs[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   traffic_light_fsm_if tlif();

   traffic_light_fsm #(
      .T_BASE(6),
      .T_EXT (3),
      .T_YEL (2)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (tlif.slave)
   );

   always #5 clk = ~clk;

   // mode: 0 = tick never, 1 = tick every cycle, 4 = tick every 4th cycle
   task automatic addSeg(input string name, input int n, input int mode,
                         input logic rst_n, input logic sensor, input logic wr,
                         input logic [2:0] main, input logic [2:0] side,
                         input logic walk, input logic wrr);
      seg_t s;
      s.name = name; s.n = n; s.mode = mode; s.rst_n = rst_n;
      s.sensor = sensor; s.wr = wr; s.main = main; s.side = side;
      s.walk = walk; s.wrr = wrr;
      segs.push_back(s);
   endtask

   task automatic checkOutput();
      vec_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_underflow: no expected entry queued");
         return;
      end
      e = exp_q.pop_front();
      if (tlif.main_lights !== e.main || tlif.side_lights !== e.side ||
          tlif.walk_lamp !== e.walk || tlif.wr_reset !== e.wrr) begin
         errors++;
         $display("[TB] FAIL %s[%0d]: got main=%b side=%b walk=%b wr_reset=%b, expected main=%b side=%b walk=%b wr_reset=%b",
                  e.name, e.idx, tlif.main_lights, tlif.side_lights,
                  tlif.walk_lamp, tlif.wr_reset, e.main, e.side, e.walk, e.wrr);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      reset_n     = v.rst_n;
      tlif.tick   = v.tick;
      tlif.sensor = v.sensor;
      tlif.wr     = v.wr;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      int ph;
      tlif.tick   = 1'b1;
      tlif.sensor = 1'b1;
      tlif.wr     = 1'b1;

      // Reset overrides all inputs, then one default period (MG 12, MY 2, SG 6, SY 2)
      addSeg("reset_hold",   2, 1, 1'b0, 1'b1, 1'b1, G, R, 1'b0, 1'b0);
      addSeg("mg1_after_rst",5, 1, 1'b1, 1'b0, 1'b0, G, R, 1'b0, 1'b0);
      addSeg("mg2_entry",    1, 1, 1'b1, 1'b0, 1'b0, G, R, 1'b0, 1'b0);
      addSeg("mg2_sens_late",5, 1, 1'b1, 1'b1, 1'b0, G, R, 1'b0, 1'b0);
      addSeg("my_default",   2, 1, 1'b1, 1'b0, 1'b0, Y, R, 1'b0, 1'b0);
      addSeg("sg_default",   6, 1, 1'b1, 1'b0, 1'b0, R, G, 1'b0, 1'b0);
      addSeg("sy_default",   2, 1, 1'b1, 1'b0, 1'b0, R, Y, 1'b0, 1'b0);
      // Sensor at MG1 exit shortens MG2 to T_EXT; wr during MG2 selects WALK
      addSeg("mg1_full",     6, 1, 1'b1, 1'b0, 1'b0, G, R, 1'b0, 1'b0);
      addSeg("mg2_ext_entry",1, 1, 1'b1, 1'b1, 1'b0, G, R, 1'b0, 1'b0);
      addSeg("mg2_ext",      2, 1, 1'b1, 1'b0, 1'b1, G, R, 1'b0, 1'b0);
      addSeg("my_before_wk", 2, 1, 1'b1, 1'b0, 1'b1, Y, R, 1'b0, 1'b0);
      addSeg("walk_entry",   1, 1, 1'b1, 1'b0, 1'b1, R, R, 1'b1, 1'b1);
      addSeg("walk_rest",    2, 1, 1'b1, 1'b0, 1'b1, R, R, 1'b1, 1'b0);
      // wr raised during WALK stays pending through a whole cycle of states
      addSeg("sg_wr_pend",   6, 1, 1'b1, 1'b0, 1'b1, R, G, 1'b0, 1'b0);
      addSeg("sy_wr_pend",   2, 1, 1'b1, 1'b0, 1'b1, R, Y, 1'b0, 1'b0);
      addSeg("mg1_wr_pend",  6, 1, 1'b1, 1'b0, 1'b1, G, R, 1'b0, 1'b0);
      addSeg("mg2_wr_pend",  6, 1, 1'b1, 1'b0, 1'b1, G, R, 1'b0, 1'b0);
      addSeg("my_wr_pend",   2, 1, 1'b1, 1'b0, 1'b1, Y, R, 1'b0, 1'b0);
      addSeg("walk2_entry",  1, 1, 1'b1, 1'b0, 1'b1, R, R, 1'b1, 1'b1);
      addSeg("walk2_second", 1, 1, 1'b1, 1'b0, 1'b0, R, R, 1'b1, 1'b0);
      // Reset in the second WALK cycle aborts to MG1, which then lasts 6 ticks
      addSeg("walk_abort",   1, 1, 1'b0, 1'b0, 1'b0, G, R, 1'b0, 1'b0);
      addSeg("mg_after_abrt",11,1, 1'b1, 1'b0, 1'b0, G, R, 1'b0, 1'b0);
      addSeg("my_after_abrt",1, 1, 1'b1, 1'b0, 1'b0, Y, R, 1'b0, 1'b0);
      // No ticks freezes everything; then every 4th tick scales durations by 4
      addSeg("tick_hold",   50, 0, 1'b1, 1'b1, 1'b1, Y, R, 1'b0, 1'b0);
      addSeg("my_slow",      7, 4, 1'b1, 1'b0, 1'b0, Y, R, 1'b0, 1'b0);
      addSeg("sg_slow",     24, 4, 1'b1, 1'b0, 1'b0, R, G, 1'b0, 1'b0);
      addSeg("sy_slow",      8, 4, 1'b1, 1'b0, 1'b0, R, Y, 1'b0, 1'b0);
      addSeg("mg_slow",     48, 4, 1'b1, 1'b0, 1'b0, G, R, 1'b0, 1'b0);
      addSeg("my_slow2",     4, 4, 1'b1, 1'b0, 1'b0, Y, R, 1'b0, 1'b0);

      ph = 0;
      foreach (segs[i]) begin
         for (int k = 0; k < segs[i].n; k++) begin
            vec_t v;
            if (segs[i].mode == 4) begin
               ph++;
               v.tick = ((ph % 4) == 0);
            end else begin
               ph = 0;
               v.tick = (segs[i].mode == 1);
            end
            v.name = segs[i].name; v.idx = k;
            v.rst_n = segs[i].rst_n; v.sensor = segs[i].sensor; v.wr = segs[i].wr;
            v.main = segs[i].main; v.side = segs[i].side;
            v.walk = segs[i].walk; v.wrr = segs[i].wrr;
            vecs.push_back(v);
         end
      end

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
      end

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
